// File: rtl/man_pkg.sv
// rtl/man_pkg.sv - shared Manchester link constants, FSM states and response error helper
package man_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, SAMPLE, CHECK} man_state_t;

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_MAN    = 3'd1;
  localparam logic [2:0] ERR_START  = 3'd2;
  localparam logic [2:0] ERR_PARITY = 3'd3;
  localparam logic [2:0] ERR_END    = 3'd4;

  localparam int RESP_BITS   = 7;
  localparam int MASTER_BITS = 14;

  localparam logic IDLE_LEVEL = 1'b1;

  // bits = {I3, I2, I1, I0, PB, EB}; first matching error in priority order wins
  function automatic logic [2:0] resp_error(input logic man, input logic start,
                                            input logic [5:0] bits);
    if (man) return ERR_MAN;
    if (start) return ERR_START;
    if (bits[1] != ^bits[5:2]) return ERR_PARITY;
    if (!bits[0]) return ERR_END;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/man_line_sync.sv
// rtl/man_line_sync.sv - two-flop synchroniser for the response line plus falling-edge detect
module man_line_sync
  import man_pkg::*;
(
  input  logic clk_in,
  input  logic rst,
  input  logic line_in,
  output logic line_s,
  output logic fall
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  always_comb begin
    sync1_d = line_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      sync1_q <= IDLE_LEVEL;
      sync2_q <= IDLE_LEVEL;
      prev_q  <= IDLE_LEVEL;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign line_s = sync2_q;
  assign fall   = prev_q & ~sync2_q;

endmodule

// File: rtl/man_decoding_master.sv
// rtl/man_decoding_master.sv - master-side Manchester decoder for the 7-bit slave response
module man_decoding_master
  import man_pkg::*;
#(
  parameter int HALF_BIT_CYC = 150,
  parameter int TIMEOUT_CYC  = 3000
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       arm,
  input  logic       line_in,
  output logic       busy,
  output logic       rx_valid,
  output logic [3:0] rx_data,
  output logic       rx_err,
  output logic [2:0] err_code,
  output logic       rx_timeout
);

  localparam int Q         = HALF_BIT_CYC / 2;
  localparam int SW        = $clog2(13 * HALF_BIT_CYC + 1);
  localparam int TW        = $clog2(TIMEOUT_CYC + 1);
  localparam int LAST_HALF = 2 * (RESP_BITS - 1);

  logic line_s, fall;

  man_line_sync u_sync (
    .clk_in  (clk_in),
    .rst     (rst),
    .line_in (line_in),
    .line_s  (line_s),
    .fall    (fall)
  );

  man_state_t    state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [SW-1:0] nxt_q, nxt_d;
  logic [3:0]    hidx_q, hidx_d;
  logic          a_q, a_d;
  logic [4:0]    bits_q, bits_d;
  logic          man_q, man_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_err_q, rx_err_d;
  logic          rx_timeout_q, rx_timeout_d;
  logic [3:0]    rx_data_q, rx_data_d;
  logic [2:0]    err_code_q, err_code_d;

  logic [5:0] full;
  logic       man_fin;
  logic [2:0] code_fin;

  assign full     = {bits_q, line_s};
  assign man_fin  = man_q | (a_q == line_s);
  assign code_fin = resp_error(man_fin, start_q, full);

  always_comb begin
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    scnt_d       = scnt_q;
    nxt_d        = nxt_q;
    hidx_d       = hidx_q;
    a_d          = a_q;
    bits_d       = bits_q;
    man_d        = man_q;
    start_d      = start_q;
    busy_d       = busy_q;
    rx_valid_d   = 1'b0;
    rx_err_d     = 1'b0;
    rx_timeout_d = 1'b0;
    rx_data_d    = rx_data_q;
    err_code_d   = err_code_q;
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = ARMED;
          busy_d  = 1'b1;
          tcnt_d  = TW'(1);
        end
      end
      ARMED: begin
        // both counters hold "cycles elapsed since the event", so compares line up with absolute offsets
        if (fall) begin
          state_d = SAMPLE;
          scnt_d  = SW'(1);
          nxt_d   = SW'(Q);
          hidx_d  = 4'd0;
          man_d   = 1'b0;
          start_d = 1'b0;
        end else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d      = IDLE;
          busy_d       = 1'b0;
          rx_timeout_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      SAMPLE: begin
        scnt_d = scnt_q + SW'(1);
        if (scnt_q == nxt_q) begin
          hidx_d = hidx_q + 4'd1;
          if (hidx_q == 4'd0) begin
            start_d = line_s;
          end else if (hidx_q[0]) begin
            a_d = line_s;
          end else begin
            man_d  = man_fin;
            bits_d = full[4:0];
          end
          if (hidx_q == 4'(LAST_HALF)) begin
            state_d = CHECK;
            if (code_fin == ERR_NONE) begin
              rx_valid_d = 1'b1;
              rx_data_d  = full[5:2];
            end else begin
              rx_err_d   = 1'b1;
              err_code_d = code_fin;
            end
          end else begin
            nxt_d = nxt_q + SW'(HALF_BIT_CYC);
          end
        end
      end
      CHECK: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      tcnt_q       <= '0;
      scnt_q       <= '0;
      nxt_q        <= '0;
      hidx_q       <= '0;
      a_q          <= 1'b0;
      bits_q       <= '0;
      man_q        <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_err_q     <= 1'b0;
      rx_timeout_q <= 1'b0;
      rx_data_q    <= '0;
      err_code_q   <= '0;
    end else begin
      state_q      <= state_d;
      tcnt_q       <= tcnt_d;
      scnt_q       <= scnt_d;
      nxt_q        <= nxt_d;
      hidx_q       <= hidx_d;
      a_q          <= a_d;
      bits_q       <= bits_d;
      man_q        <= man_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      rx_valid_q   <= rx_valid_d;
      rx_err_q     <= rx_err_d;
      rx_timeout_q <= rx_timeout_d;
      rx_data_q    <= rx_data_d;
      err_code_q   <= err_code_d;
    end
  end

  assign busy       = busy_q;
  assign rx_valid   = rx_valid_q;
  assign rx_err     = rx_err_q;
  assign rx_timeout = rx_timeout_q;
  assign rx_data    = rx_data_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_man_decoding_master.sv
// tb/tb_man_decoding_master.sv - directed bench for man_decoding_master (H=8, timeout=200)
module tb_man_decoding_master;

  localparam int H  = 8;
  localparam int TO = 200;

  logic       clk_in = 1'b0;
  logic       rst = 1'b0;
  logic       arm = 1'b0;
  logic       line_in = 1'b1;
  logic       busy, rx_valid, rx_err, rx_timeout;
  logic [3:0] rx_data;
  logic [2:0] err_code;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int t_edge, t_arm;

  int         w_first, w_cnt;
  logic [2:0] w_kind, w_code;
  logic [3:0] w_data;
  logic       w_busy_at, w_busy_after;

  man_decoding_master #(.HALF_BIT_CYC(H), .TIMEOUT_CYC(TO)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .arm        (arm),
    .line_in    (line_in),
    .busy       (busy),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_err     (rx_err),
    .err_code   (err_code),
    .rx_timeout (rx_timeout)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc = cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // b = {I3,I2,I1,I0,PB,EB}; h[12] is the low second half of ST that follows the start edge
  function automatic logic [12:0] halves(input logic [5:0] b);
    logic [12:0] h;
    h[12] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      h[13-2*k] = ~b[6-k];
      h[12-2*k] = b[6-k];
    end
    return h;
  endfunction

  task automatic pulse_arm();
    @(posedge clk_in); #1;
    arm = 1'b1;
    t_arm = cyc;
    @(posedge clk_in); #1;
    arm = 1'b0;
  endtask

  task automatic drive_frame(input logic [12:0] h);
    @(posedge clk_in); #1;
    t_edge = cyc;
    line_in = h[12];
    for (int i = 11; i >= 0; i--) begin
      repeat (H) @(posedge clk_in);
      #1 line_in = h[i];
    end
    repeat (H) @(posedge clk_in);
    #1 line_in = 1'b1;
  endtask

  task automatic watch(input int ncyc);
    w_first = -1; w_cnt = 0; w_kind = '0; w_code = '0; w_data = '0;
    w_busy_at = 1'b0; w_busy_after = 1'b1;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk_in);
      if (w_first >= 0 && cyc == w_first + 1) w_busy_after = busy;
      if (rx_valid || rx_err || rx_timeout) begin
        w_cnt++;
        if (w_first < 0) begin
          w_first = cyc;
          w_kind = {rx_timeout, rx_err, rx_valid};
          w_data = rx_data;
          w_code = err_code;
          w_busy_at = busy;
        end
      end
    end
  endtask

  task automatic frame(input logic [12:0] h);
    fork
      drive_frame(h);
      watch(130);
    join
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    n_cmp++;
    if ({busy, rx_valid, rx_err, rx_timeout, rx_data, err_code} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0", {busy, rx_valid, rx_err, rx_timeout, rx_data, err_code});
    end
    @(posedge clk_in); #1 rst = 1'b1;
    repeat (3) @(posedge clk_in);
  endtask

  task automatic test_good_frame();
    pulse_arm();
    frame(halves(6'b1010_0_1));
    n_cmp++;
    if (w_kind !== 3'b001 || w_first !== t_edge + 103) begin
      n_fail++;
      $display("FAIL good_valid: kind=%b at %0d expected 001 at %0d", w_kind, w_first, t_edge + 103);
    end
    n_cmp++;
    if (w_data !== 4'hA) begin
      n_fail++;
      $display("FAIL good_data: got %h expected a", w_data);
    end
    n_cmp++;
    if (w_cnt !== 1) begin
      n_fail++;
      $display("FAIL good_pulse_count: got %0d expected 1", w_cnt);
    end
    n_cmp++;
    if ({w_busy_at, w_busy_after} !== 2'b10) begin
      n_fail++;
      $display("FAIL good_busy: got %b expected 10", {w_busy_at, w_busy_after});
    end
  endtask

  task automatic test_errors();
    logic [5:0]  bits_tab [3] = '{6'b0001_0_1, 6'b1010_0_0, 6'b0011_0_0};
    logic [2:0]  code_tab [3] = '{3'd3, 3'd1, 3'd4};
    logic [12:0] h;
    for (int i = 0; i < 3; i++) begin
      h = halves(bits_tab[i]);
      if (i == 1) h[8] = 1'b1;
      pulse_arm();
      frame(h);
      n_cmp++;
      if (w_kind !== 3'b010 || w_first !== t_edge + 103 || w_code !== code_tab[i]) begin
        n_fail++;
        $display("FAIL err_case%0d: kind=%b at %0d code=%0d expected 010 at %0d code=%0d",
                 i, w_kind, w_first, w_code, t_edge + 103, code_tab[i]);
      end
      n_cmp++;
      if (rx_data !== 4'hA || w_cnt !== 1) begin
        n_fail++;
        $display("FAIL err_case%0d_hold: data=%h pulses=%0d expected a 1", i, rx_data, w_cnt);
      end
    end
  endtask

  task automatic test_timeout();
    pulse_arm();
    watch(250);
    n_cmp++;
    if (w_kind !== 3'b100 || w_first !== t_arm + TO || w_cnt !== 1) begin
      n_fail++;
      $display("FAIL timeout: kind=%b at %0d pulses=%0d expected 100 at %0d 1", w_kind, w_first, w_cnt, t_arm + TO);
    end
    n_cmp++;
    if (w_busy_after !== 1'b0 || err_code !== 3'd4) begin
      n_fail++;
      $display("FAIL timeout_busy_code: busy=%b code=%0d expected 0 4", w_busy_after, err_code);
    end
  endtask

  task automatic test_line_low_at_arm();
    @(posedge clk_in); #1 line_in = 1'b0;
    @(posedge clk_in);
    pulse_arm();
    watch(250);
    n_cmp++;
    if (w_kind !== 3'b100 || w_first !== t_arm + TO) begin
      n_fail++;
      $display("FAIL low_at_arm: kind=%b at %0d expected 100 at %0d", w_kind, w_first, t_arm + TO);
    end
    #1 line_in = 1'b1;
    repeat (4) @(posedge clk_in);
  endtask

  task automatic test_ignored();
    pulse_arm();
    fork
      drive_frame(halves(6'b1100_0_1));
      watch(130);
      begin
        @(posedge clk_in);
        repeat (30) @(posedge clk_in);
        #1 arm = 1'b1;
        @(posedge clk_in); #1 arm = 1'b0;
      end
    join
    n_cmp++;
    if (w_kind !== 3'b001 || w_first !== t_edge + 103 || w_data !== 4'hC || w_cnt !== 1) begin
      n_fail++;
      $display("FAIL arm_in_sample: kind=%b at %0d data=%h pulses=%0d expected 001 at %0d c 1",
               w_kind, w_first, w_data, w_cnt, t_edge + 103);
    end
    n_cmp++;
    if (w_busy_after !== 1'b0) begin
      n_fail++;
      $display("FAIL arm_in_sample_busy: got %b expected 0", w_busy_after);
    end
    @(posedge clk_in); #1 line_in = 1'b0;
    repeat (5) @(posedge clk_in);
    #1 line_in = 1'b1;
    watch(40);
    n_cmp++;
    if (w_cnt !== 0 || busy !== 1'b0 || rx_data !== 4'hC) begin
      n_fail++;
      $display("FAIL idle_edge: pulses=%0d busy=%b data=%h expected 0 0 c", w_cnt, busy, rx_data);
    end
  endtask

  task automatic test_reset_mid_frame();
    pulse_arm();
    fork
      drive_frame(halves(6'b0110_0_1));
      begin
        @(posedge clk_in);
        repeat (42) @(posedge clk_in);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({busy, rx_valid, rx_err, rx_timeout, rx_data, err_code} !== 11'd0) begin
          n_fail++;
          $display("FAIL mid_reset_outputs: got %b expected 0", {busy, rx_valid, rx_err, rx_timeout, rx_data, err_code});
        end
        @(posedge clk_in); #1 rst = 1'b1;
        watch(80);
      end
    join
    n_cmp++;
    if (w_cnt !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_rest: pulses=%0d busy=%b expected 0 0", w_cnt, busy);
    end
    pulse_arm();
    frame(halves(6'b0101_0_1));
    n_cmp++;
    if (w_kind !== 3'b001 || w_first !== t_edge + 103 || w_data !== 4'h5) begin
      n_fail++;
      $display("FAIL after_reset_frame: kind=%b at %0d data=%h expected 001 at %0d 5",
               w_kind, w_first, w_data, t_edge + 103);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_errors();
    test_timeout();
    test_ignored();
    test_line_low_at_arm();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
